// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out feeder for the serial "101" detector: first bit on sout one clock after accept.
// Backpressure: din_ready only in IDLE or on the final bit of a word, allowing gap-free back-to-back words.
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRELAST = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             accept;

    assign din_ready = (state == IDLE) || (cnt == LAST);
    assign accept    = din_valid && din_ready;

    // sreg holds the bits still to come; the bit on display already lives in sout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            sout       <= IDLE_BIT;
            sout_valid <= 1'b0;
            last_bit   <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            cnt        <= '0;
            sreg       <= MSB_FIRST ? (din << 1) : (din >> 1);
            sout       <= MSB_FIRST ? din[WIDTH-1] : din[0];
            sout_valid <= 1'b1;
            last_bit   <= 1'b0;
            busy       <= 1'b1;
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                state      <= IDLE;
                cnt        <= '0;
                sout       <= IDLE_BIT;
                sout_valid <= 1'b0;
                last_bit   <= 1'b0;
                busy       <= 1'b0;
            end else begin
                cnt      <= cnt + CW'(1);
                sreg     <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                sout     <= MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
                last_bit <= (cnt == PRELAST);
            end
        end
    end

endmodule
